// File: rtl/db_wr_arbiter.sv
// Round-robin write arbiter feeding a one-entry stage register that decodes
// into data-bank, RQ and RD register writes, with a sticky bad-address flag.
module db_wr_arbiter #(
  parameter int W     = 24,
  parameter int DEPTH = 40,
  parameter int ADDRW = 6,
  parameter int NREQ  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*ADDRW-1:0] req_addr,
  input  logic [NREQ*W-1:0]     req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  halt,
  input  logic                  err_clr,
  output logic                  db_we,
  output logic [ADDRW-1:0]      db_waddr,
  output logic [W-1:0]          db_wdata,
  output logic                  rq_we,
  output logic [W-1:0]          rq_d,
  output logic                  rd_we,
  output logic [W-1:0]          rd_d,
  output logic [1:0]            grant_id,
  output logic                  err_addr,
  output logic [15:0]           wr_count,
  output logic                  busy
);

  logic [1:0]       ptr_q, ptr_d;
  logic             stg_valid_q, stg_valid_d;
  logic [ADDRW-1:0] stg_addr_q, stg_addr_d;
  logic [W-1:0]     stg_data_q, stg_data_d;
  logic [1:0]       stg_id_q, stg_id_d;
  logic             err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;

  logic       found;
  logic [1:0] winner;
  int         idx;
  logic       xfer;
  logic       anyWe;
  logic       badAddr;

  // Scan from the pointer upward; the first valid requester wins.
  always_comb begin
    found     = 1'b0;
    winner    = 2'd0;
    idx       = 0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx[1:0];
      end
    end
    if (found && !halt && !rst) req_ready[winner] = 1'b1;
  end

  always_comb begin
    xfer        = |(req_valid & req_ready);
    ptr_d       = ptr_q;
    stg_valid_d = xfer;
    stg_addr_d  = stg_addr_q;
    stg_data_d  = stg_data_q;
    stg_id_d    = stg_id_q;
    if (xfer) begin
      ptr_d      = (winner == 2'(NREQ-1)) ? 2'd0 : winner + 2'd1;
      stg_addr_d = req_addr[int'(winner)*ADDRW +: ADDRW];
      stg_data_d = req_data[int'(winner)*W +: W];
      stg_id_d   = winner;
    end
  end

  // Address decode of the staged write; unused outputs are held at zero.
  always_comb begin
    db_we    = 1'b0;
    db_waddr = '0;
    db_wdata = '0;
    rq_we    = 1'b0;
    rq_d     = '0;
    rd_we    = 1'b0;
    rd_d     = '0;
    badAddr  = 1'b0;
    if (stg_valid_q) begin
      if (stg_addr_q < ADDRW'(DEPTH)) begin
        db_we    = 1'b1;
        db_waddr = stg_addr_q;
        db_wdata = stg_data_q;
      end else if (stg_addr_q == ADDRW'(DEPTH)) begin
        rq_we = 1'b1;
        rq_d  = stg_data_q;
      end else if (stg_addr_q == ADDRW'(DEPTH + 1)) begin
        rd_we = 1'b1;
        rd_d  = stg_data_q;
      end else begin
        badAddr = 1'b1;
      end
    end
    anyWe    = db_we | rq_we | rd_we;
    grant_id = anyWe ? stg_id_q : 2'd0;
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_comb begin
    err_d = err_q;
    if (badAddr)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    cnt_d = (anyWe && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= 2'd0;
      stg_valid_q <= 1'b0;
      stg_addr_q  <= '0;
      stg_data_q  <= '0;
      stg_id_q    <= 2'd0;
      err_q       <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      ptr_q       <= ptr_d;
      stg_valid_q <= stg_valid_d;
      stg_addr_q  <= stg_addr_d;
      stg_data_q  <= stg_data_d;
      stg_id_q    <= stg_id_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign err_addr = err_q;
  assign wr_count = cnt_q;
  assign busy     = (|req_valid) | stg_valid_q;

endmodule

// File: tb/tb_db_wr_arbiter.sv
// Directed-vector bench for db_wr_arbiter: reset, single write, rotation,
// decode, halt, mid-operation reset and counter saturation.
module tb_db_wr_arbiter;
  localparam int W = 24, DEPTH = 40, ADDRW = 6, NREQ = 3;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       reqValid;
  logic [NREQ*ADDRW-1:0] reqAddr;
  logic [NREQ*W-1:0]     reqData;
  logic [NREQ-1:0]       reqReady;
  logic                  halt, errClr;
  logic                  dbWe, rqWe, rdWe;
  logic [ADDRW-1:0]      dbWaddr;
  logic [W-1:0]          dbWdata, rqD, rdD;
  logic [1:0]            grantId;
  logic                  errAddr, busy;
  logic [15:0]           wrCount;

  int assertCount = 0;
  int failCount   = 0;

  db_wr_arbiter #(.W(W), .DEPTH(DEPTH), .ADDRW(ADDRW), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_addr(reqAddr),
    .req_data(reqData), .req_ready(reqReady), .halt(halt), .err_clr(errClr),
    .db_we(dbWe), .db_waddr(dbWaddr), .db_wdata(dbWdata), .rq_we(rqWe),
    .rq_d(rqD), .rd_we(rdWe), .rd_d(rdD), .grant_id(grantId),
    .err_addr(errAddr), .wr_count(wrCount), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [ADDRW-1:0] a, input logic [W-1:0] d);
    reqAddr[i*ADDRW +: ADDRW] = a;
    reqData[i*W +: W]         = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; reqValid = '0; reqAddr = '0; reqData = '0; halt = 1'b0; errClr = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_ready", 32'(reqReady), 0);
    checkOutput("rst_we", {dbWe, rqWe, rdWe}, 0);
    checkOutput("rst_grant", 32'(grantId), 0);
    checkOutput("rst_err", 32'(errAddr), 0);
    checkOutput("rst_count", 32'(wrCount), 0);
    checkOutput("rst_busy0", 32'(busy), 0);
    reqValid = 3'b001;
    #1;
    checkOutput("rst_ready_valid", 32'(reqReady), 0);
    checkOutput("rst_busy1", 32'(busy), 1);
    reqValid = '0;
    tick();
    @(negedge clk);
    rst = 1'b0;

    // Single requester
    reqValid = 3'b001;
    applyStimulus(0, 6'd5, 24'h123456);
    #1 checkOutput("single_ready", 32'(reqReady), 32'b001);
    tick();
    reqValid = '0;
    checkOutput("single_we", 32'(dbWe), 1);
    checkOutput("single_waddr", 32'(dbWaddr), 5);
    checkOutput("single_wdata", 32'(dbWdata), 32'h123456);
    checkOutput("single_grant", 32'(grantId), 0);
    tick();
    checkOutput("single_count", 32'(wrCount), 1);
    checkOutput("single_idle_we", 32'(dbWe), 0);

    // Rotation from reset
    pulseReset();
    checkOutput("rot_count0", 32'(wrCount), 0);
    applyStimulus(0, 6'd1, 24'hA1);
    applyStimulus(1, 6'd2, 24'hA2);
    applyStimulus(2, 6'd3, 24'hA3);
    reqValid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1 checkOutput($sformatf("rot_ready%0d", c), 32'(reqReady), 32'(1 << (c % 3)));
      tick();
      checkOutput($sformatf("rot_we%0d", c), 32'(dbWe), 1);
      checkOutput($sformatf("rot_grant%0d", c), 32'(grantId), 32'(c % 3));
      checkOutput($sformatf("rot_waddr%0d", c), 32'(dbWaddr), 32'(c % 3 + 1));
    end
    reqValid = '0;
    tick();
    checkOutput("rot_idle_we", 32'(dbWe), 0);
    checkOutput("rot_count", 32'(wrCount), 6);

    // Address decode boundaries
    reqValid = 3'b001;
    applyStimulus(0, 6'd39, 24'h55);
    tick();
    checkOutput("dec39_we", 32'(dbWe), 1);
    checkOutput("dec39_waddr", 32'(dbWaddr), 39);
    applyStimulus(0, 6'd40, 24'h7);
    tick();
    checkOutput("dec40_we", {dbWe, rqWe, rdWe}, 32'b010);
    checkOutput("dec40_rqd", 32'(rqD), 7);
    checkOutput("dec40_waddr", 32'(dbWaddr), 0);
    checkOutput("dec40_wdata", 32'(dbWdata), 0);
    applyStimulus(0, 6'd41, 24'h9);
    tick();
    checkOutput("dec41_we", {dbWe, rqWe, rdWe}, 32'b001);
    checkOutput("dec41_rdd", 32'(rdD), 9);
    checkOutput("dec41_rqd", 32'(rqD), 0);
    reqValid = 3'b010;
    applyStimulus(1, 6'd50, 24'hB);
    tick();
    reqValid = '0;
    checkOutput("dec50_we", {dbWe, rqWe, rdWe}, 0);
    checkOutput("dec50_grant", 32'(grantId), 0);
    checkOutput("dec50_rdd", 32'(rdD), 0);
    checkOutput("dec50_err_early", 32'(errAddr), 0);
    tick();
    checkOutput("dec50_err", 32'(errAddr), 1);
    checkOutput("dec_count", 32'(wrCount), 9);
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    checkOutput("errclr", 32'(errAddr), 0);

    // Halt: pointer sits at requester 2 here
    reqValid = 3'b111;
    applyStimulus(0, 6'd10, 24'hA0);
    applyStimulus(1, 6'd11, 24'hB0);
    applyStimulus(2, 6'd12, 24'hC0);
    #1 checkOutput("halt_pre_ready", 32'(reqReady), 32'b100);
    tick();
    halt = 1'b1;
    #1;
    checkOutput("halt_drain_we", 32'(dbWe), 1);
    checkOutput("halt_drain_grant", 32'(grantId), 2);
    checkOutput("halt_drain_waddr", 32'(dbWaddr), 12);
    checkOutput("halt_ready", 32'(reqReady), 0);
    tick();
    checkOutput("halt_we_off", 32'(dbWe), 0);
    checkOutput("halt_ready2", 32'(reqReady), 0);
    tick();
    checkOutput("halt_busy", 32'(busy), 1);
    halt = 1'b0;
    #1 checkOutput("halt_release_ready", 32'(reqReady), 32'b001);
    tick();
    reqValid = '0;
    checkOutput("halt_release_grant", 32'(grantId), 0);
    checkOutput("halt_release_waddr", 32'(dbWaddr), 10);

    // Reset mid-operation, with set-beats-clear on the error flag first
    reqValid = 3'b001;
    applyStimulus(0, 6'd60, 24'h1);
    tick();
    errClr = 1'b1;
    reqValid = 3'b010;
    applyStimulus(1, 6'd3, 24'h33);
    tick();
    errClr = 1'b0;
    checkOutput("err_set_wins", 32'(errAddr), 1);
    checkOutput("mid_staged_we", 32'(dbWe), 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_we", {dbWe, rqWe, rdWe}, 0);
    checkOutput("mid_err", 32'(errAddr), 0);
    checkOutput("mid_count", 32'(wrCount), 0);
    checkOutput("mid_ready", 32'(reqReady), 0);
    checkOutput("mid_busy", 32'(busy), 1);
    tick();
    checkOutput("mid_we_hold", {dbWe, rqWe, rdWe}, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 6'd4, 24'h44);
    reqValid = 3'b011;
    #1 checkOutput("mid_ptr_ready", 32'(reqReady), 32'b001);
    tick();
    reqValid = '0;
    checkOutput("mid_ptr_grant", 32'(grantId), 0);
    checkOutput("mid_ptr_waddr", 32'(dbWaddr), 4);

    // Saturation of the write counter
    pulseReset();
    applyStimulus(0, 6'd0, 24'h0);
    reqValid = 3'b001;
    repeat (65534) tick();
    checkOutput("sat_near", 32'(wrCount), 32'hFFFD);
    repeat (4) tick();
    checkOutput("sat_hold", 32'(wrCount), 32'hFFFF);
    checkOutput("sat_we", 32'(dbWe), 1);
    reqValid = '0;
    repeat (2) tick();
    checkOutput("sat_final", 32'(wrCount), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/db_wr_arbiter.md
DB_WR_ARBITER -- requirements
Module: db_wr_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 24, meaning the data word width.
REQ-002 The block SHALL have parameter DEPTH, default 40, meaning the data bank entry count.
REQ-003 The block SHALL have parameter ADDRW, default 6, meaning the address width, with 2^ADDRW >= DEPTH+2.
REQ-004 The block SHALL have parameter NREQ, default 3, meaning the requester count, range 2..4.
REQ-005 The block SHALL have port clk  input  1  meaning the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-007 The block SHALL have port req_valid  input  NREQ  meaning per-requester write request.
REQ-008 The block SHALL have port req_addr  input  NREQ*ADDRW  meaning packed target addresses, requester i at bits [i*ADDRW +: ADDRW].
REQ-009 The block SHALL have port req_data  input  NREQ*W  meaning packed write data, requester i at bits [i*W +: W].
REQ-010 The block SHALL have port req_ready  output  NREQ  meaning per-requester grant, one-hot or zero.
REQ-011 The block SHALL have port halt  input  1  meaning suppress new grants.
REQ-012 The block SHALL have port err_clr  input  1  meaning clear the sticky address error.
REQ-013 The block SHALL have ports db_we (1), db_waddr (ADDRW), db_wdata (W), all outputs, meaning the data bank write port.
REQ-014 The block SHALL have ports rq_we (1), rq_d (W), rd_we (1), rd_d (W), all outputs, meaning the RQ and RD register writes.
REQ-015 The block SHALL have port grant_id  output  2  meaning the index of the requester issued in the current write cycle.
REQ-016 The block SHALL have port err_addr  output  1  meaning a sticky flag for an out-of-range address.
REQ-017 The block SHALL have port wr_count  output  16  meaning the count of completed writes.
REQ-018 The block SHALL have port busy  output  1  meaning any req_valid is set or the stage register holds a write.

Function
REQ-019 Arbitration SHALL be round-robin: the priority pointer ptr indexes the highest-priority requester, followed by ptr+1 .. ptr+NREQ-1 mod NREQ.
REQ-020 req_ready[i] SHALL be asserted combinationally when halt=0, req_valid[i]=1, and i is the highest-priority valid requester; all other req_ready bits SHALL be 0.
REQ-021 A transfer SHALL occur when req_valid[i]&req_ready[i]=1; the requester SHALL hold valid, addr, and data stable until that transfer.
REQ-022 On a transfer, ptr SHALL load (winner+1) mod NREQ; otherwise ptr SHALL hold, including while halt=1.
REQ-023 The winner's addr, data, and index SHALL be captured into a one-entry stage register on the transfer edge.
REQ-024 Write outputs SHALL be driven from the stage register in the cycle after the grant, giving a latency of exactly 1 cycle; throughput SHALL be one write per cycle with no bubbles.
REQ-025 Decode: stage addr < DEPTH -> db_we=1, db_waddr=addr, db_wdata=data.
REQ-026 Decode: stage addr == DEPTH -> rq_we=1, rq_d=data.
REQ-027 Decode: stage addr == DEPTH+1 -> rd_we=1, rd_d=data.
REQ-028 Decode: stage addr > DEPTH+1 -> no write enable asserted, err_addr set on the following edge, and wr_count not incremented.
REQ-029 At most one of db_we, rq_we, and rd_we SHALL be high in any cycle.
REQ-030 When no enable is asserted, db_waddr, db_wdata, rq_d, and rd_d SHALL be 0.
REQ-031 grant_id SHALL equal the stage index when any write enable is high, and 0 otherwise.
REQ-032 wr_count SHALL increment by 1 per cycle with any write enable high, and SHALL saturate at 16'hFFFF.
REQ-033 err_addr SHALL stay set until err_clr=1; if a set and err_clr occur in the same cycle, the set SHALL win.
REQ-034 When halt rises, the stage register SHALL still drain its pending write; only new grants SHALL be blocked.
REQ-035 The same-address write-to-read forwarding SHALL remain the data bank's responsibility; this block SHALL NOT reorder writes.

Reset
REQ-036 While rst=1, the block SHALL clear ptr=0, stage valid=0, all write enables=0, all address/data outputs=0, grant_id=0, err_addr=0, wr_count=0, and busy reflecting req_valid only.
REQ-037 Assertion of rst mid-operation SHALL discard any staged write; no enable SHALL pulse after reset asserts.
REQ-038 req_ready SHALL be 0 while rst=1.

Verification
REQ-039 Scenario, single requester: req 0 valid, addr=5, data=24'h123456 -> ready0 in the same cycle; the next cycle gives db_we=1, db_waddr=5, db_wdata=24'h123456, grant_id=0, and wr_count=1.
REQ-040 Scenario, rotation: all three requesters valid continuously for 6 cycles from reset -> grant order 0,1,2,0,1,2 with db_we high for 6 consecutive cycles.
REQ-041 Scenario, address decode: addr=40 with data=7 -> rq_we=1 and rq_d=7; addr=41 -> rd_we=1; addr=50 -> no enables, err_addr=1; err_clr -> err_addr=0.
REQ-042 Scenario, halt: halt=1 raised on the cycle after a grant -> the staged write still issues; then no req_ready while halted and ptr unchanged; on release, the next grant starts from the held ptr.
REQ-043 Scenario, reset mid-operation: rst pulses while the stage holds a write -> no write enable is issued, and wr_count, err_addr, and ptr read 0 after release.
REQ-044 Scenario, saturation: wr_count forced to within 2 of 16'hFFFF, then 4 writes -> wr_count holds at 16'hFFFF.
